// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the requester drives start and
// the operands, and the adder returns busy, done and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock. A full-adder slice
// is built from two half-adder stages plus an OR, and a carry flop closes the loop.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Half-adder primitive: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] psum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_out_r;

  logic [1:0]       ha1_s;
  logic [1:0]       ha2_s;
  logic             bit_s;
  logic             c_next_s;
  logic [WIDTH-1:0] psum_next_s;
  logic             last_s;

  // Full-adder slice on the current operand LSBs and the carry flop.
  always_comb begin
    ha1_s       = half_add(a_sr_r[0], b_sr_r[0]);
    ha2_s       = half_add(ha1_s[0], carry_r);
    bit_s       = ha2_s[0];
    c_next_s    = ha1_s[1] | ha2_s[1];
    psum_next_s = {bit_s, psum_r[WIDTH-1:1]};
    last_s      = (cnt_r == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers. The edge that leaves DONE samples start
  // like an IDLE edge, so a held start yields one addition per WIDTH+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      psum_r      <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr_r  <= bus.a;
            b_sr_r  <= bus.b;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
          psum_r  <= psum_next_s;
          carry_r <= c_next_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum_r       <= psum_next_s;
            carry_out_r <= c_next_s;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the latency, overflow,
// ignored-start and reset cases, and a 4-bit instance swept exhaustively back to back.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit addition: start pulse, latency, busy length, result, done width.
  task automatic add8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] exp_sum, input logic exp_co);
    int k;
    int nbusy;
    @(negedge clk);
    bus8.a = av;
    bus8.b = bv;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    k = 0;
    nbusy = 0;
    while (bus8.done !== 1'b1 && k < 40) begin
      if (bus8.busy === 1'b1) nbusy++;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, 8);
    chk({tag, "_busy_cycles"}, nbusy, 8);
    chk({tag, "_busy_at_done"}, {31'd0, bus8.busy}, 32'd0);
    chk({tag, "_sum"}, {24'd0, bus8.sum}, {24'd0, exp_sum});
    chk({tag, "_carry"}, {31'd0, bus8.carry_out}, {31'd0, exp_co});
    @(negedge clk);
    chk({tag, "_done_fall"}, {31'd0, bus8.done}, 32'd0);
  endtask

  initial begin
    int k;
    int ndone;
    logic [7:0] idx;
    logic [7:0] nxt;
    logic [4:0] exp5;

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    bus4.start = 1'b0; bus4.a = 4'h0;  bus4.b = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("rst_done", {31'd0, bus8.done}, 32'd0);
    chk("rst_sum", {24'd0, bus8.sum}, 32'd0);
    chk("rst_carry", {31'd0, bus8.carry_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, bus8.busy}, 32'd0);

    add8("zero", 8'h00, 8'h00, 8'h00, 1'b0);
    add8("ovf", 8'hFF, 8'h01, 8'h00, 1'b1);
    add8("c8_64", 8'hC8, 8'h64, 8'h2C, 1'b1);

    // Start pulse and operand changes during RUN must not disturb the addition.
    @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'h33; bus8.b = 8'h77;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done === 1'b1) begin
        ndone++;
        chk("ign_sum", {24'd0, bus8.sum}, 32'h0000_00FF);
        chk("ign_carry", {31'd0, bus8.carry_out}, 32'd0);
      end
      @(negedge clk);
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_sum_held", {24'd0, bus8.sum}, 32'h0000_00FF);

    // sum must keep the old result throughout the next RUN.
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_in_run", {24'd0, bus8.sum}, 32'h0000_00FF);
    k = 0;
    while (bus8.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("next_sum", {24'd0, bus8.sum}, 32'h0000_0046);
    @(negedge clk);

    // Reset in the 5th RUN cycle aborts the addition without a done.
    bus8.a = 8'h0F; bus8.b = 8'hF1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus8.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
    chk("abort_done", {31'd0, bus8.done}, 32'd0);
    chk("abort_sum", {24'd0, bus8.sum}, 32'd0);
    chk("abort_carry", {31'd0, bus8.carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    add8("post_rst", 8'h03, 8'h04, 8'h07, 1'b0);

    // 4-bit exhaustive sweep with start held high: one result every 5 cycles.
    @(negedge clk);
    bus4.a = 4'h0; bus4.b = 4'h0; bus4.start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      exp5 = {1'b0, idx[7:4]} + {1'b0, idx[3:0]};
      @(negedge clk);
      chk("w4_done_low", {31'd0, bus4.done}, 32'd0);
      if (i < 255) begin
        nxt = idx + 8'd1;
        bus4.a = nxt[7:4];
        bus4.b = nxt[3:0];
      end else begin
        bus4.start = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("w4_early_done", {31'd0, bus4.done}, 32'd0);
      @(negedge clk);
      chk("w4_done", {31'd0, bus4.done}, 32'd1);
      chk("w4_result", {27'd0, bus4.carry_out, bus4.sum}, {27'd0, exp5});
    end
    @(negedge clk);
    chk("w4_final_done_low", {31'd0, bus4.done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
